// File: rtl/block_shift_pipe.sv
// ============================================================================
//  Module      : block_shift_pipe
//  Description : Pipelined valid/ready element-array shifter/rotator. The
//                shift amount is split into bit groups, one group per stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module block_shift_pipe #(
    parameter int ELMS   = 8,
    parameter int DATA   = 8,
    parameter int SHAMT  = $clog2(ELMS + 1),
    parameter int STAGES = 2,
    parameter int GRP    = (SHAMT + STAGES - 1) / STAGES
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ELMS-1:0][DATA-1:0]  in,
    input  logic [SHAMT-1:0]           shamt,
    input  logic                       rotate,
    input  logic                       to_right,
    input  logic [DATA-1:0]            fill,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ELMS-1:0][DATA-1:0]  out
);

    localparam int c_PADW = GRP * STAGES;
    localparam int c_IDXW = $clog2(ELMS);

    typedef logic [ELMS-1:0][DATA-1:0] arr_t;

    // One power-of-two move; amt is elaboration-constant at every call site.
    function automatic arr_t f_move(input arr_t a, input int amt, input logic rot,
                                    input logic right, input logic [DATA-1:0] fv);
        arr_t res;
        int   src;
        int   r;
        res = a;
        r   = amt % ELMS;
        for (int j = 0; j < ELMS; j++) begin
            if (rot) begin
                src    = right ? (j + r) % ELMS : (j - r + ELMS) % ELMS;
                res[j] = a[c_IDXW'(src)];
            end else begin
                src = right ? j + amt : j - amt;
                if (src >= 0 && src < ELMS) res[j] = a[c_IDXW'(src)];
                else                        res[j] = fv;
            end
        end
        return res;
    endfunction

    arr_t                  r_data  [STAGES];
    logic                  r_rot   [STAGES];
    logic                  r_right [STAGES];
    logic [DATA-1:0]       r_fill  [STAGES];
    logic [c_PADW-1:0]     r_sh    [STAGES];
    logic [STAGES-1:0]     r_valid;

    logic [STAGES-1:0]     w_adv;
    logic [STAGES-1:0]     w_load;
    logic                  w_acc;
    logic [c_PADW-1:0]     w_sh_pad;
    logic                  w_unused;

    assign w_sh_pad = c_PADW'(shamt);

    // Ready chain walks back from the output so a full pipe can still accept.
    always_comb begin
        w_adv  = '0;
        w_load = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (k == STAGES - 1) w_adv[k] = r_valid[k] & out_ready;
            else                 w_adv[k] = r_valid[k] & (!r_valid[k+1] | w_adv[k+1]);
        end
        in_ready  = !r_valid[0] | w_adv[0];
        w_acc     = in_valid & in_ready & !flush;
        w_load[0] = w_acc;
        for (int k = 1; k < STAGES; k++) w_load[k] = w_adv[k-1];
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_valid <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++)
                r_valid[k] <= w_load[k] | (r_valid[k] & !w_adv[k]);
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        arr_t              w_src;
        logic              w_src_rot;
        logic              w_src_right;
        logic [DATA-1:0]   w_src_fill;
        logic [c_PADW-1:0] w_src_sh;
        logic [GRP-1:0]    w_grp;
        arr_t              w_res;

        if (k == 0) begin : g_head
            assign w_src       = in;
            assign w_src_rot   = rotate;
            assign w_src_right = to_right;
            assign w_src_fill  = fill;
            assign w_src_sh    = w_sh_pad;
        end else begin : g_body
            assign w_src       = r_data[k-1];
            assign w_src_rot   = r_rot[k-1];
            assign w_src_right = r_right[k-1];
            assign w_src_fill  = r_fill[k-1];
            assign w_src_sh    = r_sh[k-1];
        end

        assign w_grp = w_src_sh[k*GRP +: GRP];

        always_comb begin
            w_res = w_src;
            for (int b = 0; b < GRP; b++) begin
                if (w_grp[b])
                    w_res = f_move(w_res, 1 << (k * GRP + b), w_src_rot, w_src_right, w_src_fill);
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_data[k]  <= '0;
                r_rot[k]   <= 1'b0;
                r_right[k] <= 1'b0;
                r_fill[k]  <= '0;
                r_sh[k]    <= '0;
            end else if (w_load[k]) begin
                r_data[k]  <= w_res;
                r_rot[k]   <= w_src_rot;
                r_right[k] <= w_src_right;
                r_fill[k]  <= w_src_fill;
                r_sh[k]    <= w_src_sh;
            end
        end
    end

    // Last stage's control fields have no consumer downstream.
    assign w_unused = ^{r_sh[STAGES-1], r_fill[STAGES-1], r_rot[STAGES-1], r_right[STAGES-1]};

    assign out       = r_data[STAGES-1];
    assign out_valid = r_valid[STAGES-1];

endmodule

`default_nettype wire

// File: tb/tb_block_shift_pipe.sv
// ============================================================================
//  Module      : tb_block_shift_pipe
//  Description : Directed scoreboard bench for block_shift_pipe (8x8/2 stages
//                and 5x8/3 stages instances).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_block_shift_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             a_flush, a_in_valid, a_in_ready, a_rot, a_right, a_out_valid, a_out_ready;
    logic [7:0][7:0]  a_in, a_out;
    logic [3:0]       a_shamt;
    logic [7:0]       a_fill;

    logic             b_flush, b_in_valid, b_in_ready, b_rot, b_right, b_out_valid, b_out_ready;
    logic [4:0][7:0]  b_in, b_out;
    logic [2:0]       b_shamt;
    logic [7:0]       b_fill;

    block_shift_pipe #(.ELMS(8), .DATA(8), .STAGES(2)) u_dut_a (
        .clk(clk), .reset(rst), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in(a_in), .shamt(a_shamt), .rotate(a_rot), .to_right(a_right), .fill(a_fill),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out(a_out));

    block_shift_pipe #(.ELMS(5), .DATA(8), .STAGES(3)) u_dut_b (
        .clk(clk), .reset(rst), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in(b_in), .shamt(b_shamt), .rotate(b_rot), .to_right(b_right), .fill(b_fill),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out(b_out));

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [63:0] q_a[$];
    logic [63:0] q_b[$];
    bit          a_acc;
    int          a_pops = 0;
    bit          a_prev_stall = 1'b0;
    logic [63:0] a_prev_out;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference straight from the element equations, independent of stages.
    function automatic logic [63:0] model(input int elms, input logic [63:0] a, input int s,
                                          input bit rot, input bit right, input logic [7:0] f);
        logic [63:0] r;
        logic [7:0]  v;
        int          src;
        int          e;
        r = '0;
        for (int j = 0; j < elms; j++) begin
            if (rot) begin
                e   = s % elms;
                src = right ? (j + e) % elms : (j - e + elms) % elms;
                v   = 8'(a >> (src * 8));
            end else begin
                src = right ? j + s : j - s;
                v   = (src >= 0 && src < elms) ? 8'(a >> (src * 8)) : f;
            end
            r = r | (64'(v) << (j * 8));
        end
        return r;
    endfunction

    task automatic step();
        @(negedge clk);
        a_acc = 1'b0;
        if (a_out_valid && a_out_ready) begin
            a_pops++;
            if (q_a.size() == 0) chk("a_spurious_out", 1, 0);
            else                 chk("a_out_data", a_out, q_a.pop_front());
        end
        if (a_prev_stall) chk("a_stall_hold", a_out, a_prev_out);
        a_prev_stall = a_out_valid && !a_out_ready && !rst && !a_flush;
        a_prev_out   = a_out;
        if (a_in_valid && a_in_ready && !a_flush && !rst) begin
            a_acc = 1'b1;
            q_a.push_back(model(8, a_in, int'(a_shamt), a_rot, a_right, a_fill));
        end
        if (a_flush || rst) q_a.delete();

        if (b_out_valid && b_out_ready) begin
            if (q_b.size() == 0) chk("b_spurious_out", 1, 0);
            else                 chk("b_out_data", 64'(b_out), q_b.pop_front());
        end
        if (b_in_valid && b_in_ready && !b_flush && !rst)
            q_b.push_back(model(5, 64'(b_in), int'(b_shamt), b_rot, b_right, b_fill));
        if (b_flush || rst) q_b.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic [63:0] d, input int s, input bit rot, input bit right,
                         input logic [7:0] f);
        a_in       = d;
        a_shamt    = 4'(s);
        a_rot      = rot;
        a_right    = right;
        a_fill     = f;
        a_in_valid = 1'b1;
    endtask

    task automatic set_b(input logic [39:0] d, input int s, input bit rot, input logic [7:0] f);
        b_in       = d;
        b_shamt    = 3'(s);
        b_rot      = rot;
        b_right    = 1'b0;
        b_fill     = f;
        b_in_valid = 1'b1;
    endtask

    task automatic set_a_rand(input logic [7:0] tag, input bit plain);
        logic [63:0] d;
        d = {$urandom(), $urandom()};
        d[7:0] = tag;
        if (plain) set_a(d, 0, 1'b0, 1'b0, 8'h00);
        else       set_a(d, $urandom_range(0, 9), 1'($urandom()), 1'($urandom()), 8'($urandom()));
    endtask

    initial begin
        int tag;
        int base;
        int c;

        rst = 1'b1;
        a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
        a_in = '0; a_shamt = '0; a_rot = 1'b0; a_right = 1'b0; a_fill = '0;
        b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1;
        b_in = '0; b_shamt = '0; b_rot = 1'b0; b_right = 1'b0; b_fill = '0;
        @(posedge clk); #1;
        step();
        step();
        rst = 1'b0;
        chk("reset_out_valid", 64'(a_out_valid), 0);
        chk("reset_in_ready", 64'(a_in_ready), 1);
        chk("reset_out", a_out, 0);
        chk("reset_b_in_ready", 64'(b_in_ready), 1);

        // Left shift by 3 with fill, two-edge latency
        set_a(64'h0706050403020100, 3, 1'b0, 1'b0, 8'hFF);
        step();
        a_in_valid = 1'b0;
        chk("lat_out_valid_early", 64'(a_out_valid), 0);
        step();
        chk("lat_out_valid", 64'(a_out_valid), 1);
        chk("shl3_out", a_out, 64'h04030201_00FFFFFF);
        step();

        // Rotate right by 10 (effective 2)
        set_a(64'h0706050403020100, 10, 1'b1, 1'b1, 8'h00);
        step();
        a_in_valid = 1'b0;
        step();
        chk("rotr10_out", a_out, 64'h01000706_05040302);
        step();

        // Pass-through and full-width shift, back to back
        set_a(64'h0706050403020100, 0, 1'b0, 1'b0, 8'hFF);
        step();
        set_a(64'h0706050403020100, 8, 1'b0, 1'b1, 8'hFF);
        step();
        a_in_valid = 1'b0;
        chk("shamt0_out", a_out, 64'h07060504_03020100);
        step();
        chk("shr8_out", a_out, 64'hFFFFFFFF_FFFFFFFF);
        step();

        // Six tagged transfers, output stalled for four cycles
        tag = 0; base = a_pops; c = 0;
        while ((tag < 6 || (a_pops - base) < 6) && c < 40) begin
            a_out_ready = (c >= 4);
            if (tag < 6) set_a_rand(8'(8'h10 + tag), 1'b1);
            else         a_in_valid = 1'b0;
            if (c == 2 || c == 3) chk("stall_in_ready", 64'(a_in_ready), 0);
            if (c >= 4 && (a_pops - base) < 6) chk("stream_no_gap", 64'(a_out_valid), 1);
            step();
            if (a_acc) tag++;
            c++;
        end
        chk("stream_accepted", 64'(tag), 6);
        chk("stream_emitted", 64'(a_pops - base), 6);
        chk("stream_q_empty", 64'(q_a.size()), 0);

        // Sustained throughput with random modes
        a_out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_a_rand(8'(8'h40 + i), 1'b0);
            chk("sustain_in_ready", 64'(a_in_ready), 1);
            if (i >= 2) chk("sustain_out_valid", 64'(a_out_valid), 1);
            step();
        end
        a_in_valid = 1'b0;
        for (int i = 0; i < 10 && q_a.size() != 0; i++) step();
        chk("drain_q_empty", 64'(q_a.size()), 0);

        // Flush with two in flight and a third offered
        a_out_ready = 1'b0;
        set_a_rand(8'h80, 1'b0); step();
        set_a_rand(8'h81, 1'b0); step();
        chk("flush_pipe_full", 64'(a_in_ready), 0);
        set_a_rand(8'h82, 1'b0);
        a_flush = 1'b1;
        step();
        a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
        chk("flush_out_valid", 64'(a_out_valid), 0);
        chk("flush_in_ready", 64'(a_in_ready), 1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("flush_stays_empty", 64'(a_out_valid), 0);
        end

        // Reset mid-stream
        set_a_rand(8'h90, 1'b0); step();
        set_a_rand(8'h91, 1'b0); step();
        set_a_rand(8'h92, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0; a_in_valid = 1'b0;
        chk("rst_mid_in_ready", 64'(a_in_ready), 1);
        chk("rst_mid_out_valid", 64'(a_out_valid), 0);
        chk("rst_mid_out", a_out, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_stays_empty", 64'(a_out_valid), 0);
        end
        set_a(64'h0706050403020100, 1, 1'b1, 1'b0, 8'h00);
        step();
        a_in_valid = 1'b0;
        for (int i = 0; i < 6 && q_a.size() != 0; i++) step();
        chk("post_rst_q_empty", 64'(q_a.size()), 0);

        // Five-element, three-stage instance
        set_b(40'hA4A3A2A1A0, 7, 1'b1, 8'h00);
        step();
        b_in_valid = 1'b0;
        step();
        chk("b_lat_early", 64'(b_out_valid), 0);
        step();
        chk("b_lat_out_valid", 64'(b_out_valid), 1);
        chk("b_rotl7_out", 64'(b_out), 64'hA2A1A0A4A3);
        step();
        set_b(40'hA4A3A2A1A0, 5, 1'b0, 8'h5A);
        step();
        b_in_valid = 1'b0;
        step();
        step();
        chk("b_shl5_out", 64'(b_out), 64'h5A5A5A5A5A);
        for (int i = 0; i < 6 && q_b.size() != 0; i++) step();
        chk("b_q_empty", 64'(q_b.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/block_shift_pipe.md
# block_shift_pipe

Pipelined, handshaked element-array shifter/rotator for the datapath library. It moves whole `DATA`-bit elements of an `ELMS`-entry array by a runtime amount, with shift/rotate and direction selected per transfer. The shift is split into `STAGES` registered stages so wide arrays close timing, with full valid/ready backpressure at one transfer per cycle. It replaces the purely combinational element shifter wherever the shift sits on a timing-critical path between queues.

## Interface
- `ELMS`, 8: number of elements; any value ≥ 2, power of two not required.
- `DATA`, 8: element width in bits.
- `SHAMT`, `$clog2(ELMS+1)`: shift-amount width (derived; do not override).
- `STAGES`, 2: pipeline register stages, 1..`SHAMT`.
- `GRP`, `(SHAMT+STAGES-1)/STAGES`: shamt bits handled per stage (derived).

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `flush` in 1: synchronous discard of all in-flight transfers.
- `in_valid` in 1: input transfer valid.
- `in_ready` out 1: block accepts the input this cycle.
- `in` in `[ELMS-1:0][DATA-1:0]`: element array.
- `shamt` in `SHAMT`: shift amount in elements.
- `rotate` in 1: 1 = rotate, 0 = shift.
- `to_right` in 1: 1 = toward element 0, 0 = toward element `ELMS-1`.
- `fill` in `DATA`: value inserted into vacated elements (shift mode only).
- `out_valid` out 1: output transfer valid.
- `out_ready` in 1: downstream accepts.
- `out` out `[ELMS-1:0][DATA-1:0]`: shifted array.

## Operation
- Left shift by s: `out[j] = in[j-s]` for j ≥ s, else `fill`. Right shift: `out[j] = in[j+s]` for j+s < `ELMS`, else `fill`.
- Shift with s ≥ `ELMS`: every element = `fill`.
- Rotate: the effective amount is s mod `ELMS`. Left rotate: `out[j] = in[(j-s) mod ELMS]`. Right rotate: `out[j] = in[(j+s) mod ELMS]`.
- Decomposition: stage k applies `shamt` bits `[k*GRP +: GRP]` (bits ≥ `SHAMT` are treated as 0) as successive power-of-two moves of 2^b elements.
  - Shifts and rotates compose additively, so the result is exact for non-power-of-two `ELMS`.
  - Each stage register holds the partial array plus `rotate`, `to_right`, `fill` and the unused shamt bits. Stage k's register holds the result after bit groups 0..k.
- Per-stage `valid` flag. A stage loads when it is empty or when its content moves downstream this cycle.
- `out` and `out_valid` are driven directly from the last stage register.
- `in_ready = !valid[0] | advance[0]`, where `advance[k] = valid[k] & (k==last ? out_ready : (!valid[k+1] | advance[k+1]))`. The ready chain is combinational from `out_ready`.
- Accept = `in_valid & in_ready`. Output transfer = `out_valid & out_ready`.
- `flush`:
  - clears all valid flags next cycle and ignores any input presented in that cycle.
  - `in_ready` remains asserted per its equation.
  - The data registers are not cleared.
- The block reorders, drops and duplicates nothing. Output order equals accept order.

## Timing
- Reset: all valid flags 0, so `out_valid` = 0 and `in_ready` = 1 in the first cycle after reset; `out` = all zeros.
- `reset` wins over `flush` and over accepts. Asserting it mid-stream discards all in-flight transfers.
- Latency: a transfer accepted at edge t is presented on `out` after edge t+`STAGES-1`, i.e. `out_valid` rises in the cycle after acceptance when `STAGES`=1. A non-stalled stream sees `STAGES` cycles of latency counted in edges.
- Throughput: 1 transfer/cycle while `out_ready` = 1.
- Capacity: `STAGES` transfers. With `out_ready` held 0, `in_ready` falls after `STAGES` accepts.
- Stall: while `out_valid & !out_ready`, `out` holds stable.
- Same-cycle output and input with the pipe full: both transfers complete; the pipe stays full with no bubble.
- `in_valid` may drop without a transfer. Inputs are sampled only on accept.

## Test plan
- `ELMS`=8, `DATA`=8, `STAGES`=2; `in[i]=i`, shamt=3, left shift, fill=0xFF → after 2 edges `out` = {4,3,2,1,0,FF,FF,FF} (elements 7..0).
- Rotate right, shamt=10 → effective amount 2 → `out[j] = (j+2) mod 8`, i.e. {1,0,7,6,5,4,3,2}. Also shamt=0 → `out` = `in`; shift with shamt=8 → all 0xFF.
- Stream 6 back-to-back transfers tagged 0x10..0x15 with `out_ready`=0 for 4 cycles:
  - `in_ready` falls after 2 accepts.
  - The output holds stable while stalled.
  - On release, all 6 emerge in order with no gaps or duplicates.
- Pipe full and `out_ready`=1 with `in_valid`=1 every cycle → one transfer per cycle sustained, `in_ready` stays 1.
- `flush` with 2 transfers in flight and a third offered → `out_valid`=0 the next cycle and none of the three ever appears. Then `reset` mid-stream → same, with `in_ready`=1 after it.
- `ELMS`=5, `STAGES`=3, rotate left, shamt=7 → effective amount 2, `out[j] = in[(j-2) mod 5]`. Shift left, shamt=5 → all `fill`.
